// File: rtl/xalu_param.sv
// xalu_param: parametrised multiply/divide unit holding architectural HI/LO.
// Results are computed combinationally when an op is accepted and parked in
// pending registers. They are committed to HI/LO once the configured latency
// has elapsed, so the pipeline sees a fixed, predictable busy window.
// Optional feature macro: XALU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU
// accumulate ops (op codes 6-9). Without it those codes are NOPs.
module xalu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef XALU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t              state;
  logic [CW-1:0]       counter;
  logic [WIDTH-1:0]    pend_hi;
  logic [WIDTH-1:0]    pend_lo;
  logic                pend_dz;

  logic [2*WIDTH-1:0]  a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [WIDTH-1:0]    b_nz, abs_a, abs_b, mag_q, mag_r;
  logic [WIDTH-1:0]    sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic [WIDTH-1:0]    res_hi, res_lo;
  logic                res_dz, is_multi, is_div;

  // Full-width products; a truncated product of extended operands is exact.
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide via magnitudes; INT_MIN/-1 naturally wraps back to INT_MIN.
  // A zero divisor is replaced by one so the divider never sees zero.
  assign b_nz   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign abs_a  = a[WIDTH-1] ? -a : a;
  assign abs_b  = b_nz[WIDTH-1] ? -b_nz : b_nz;
  assign mag_q  = abs_a / abs_b;
  assign mag_r  = abs_a % abs_b;
  assign sdiv_q = (a[WIDTH-1] ^ b_nz[WIDTH-1]) ? -mag_q : mag_q;
  assign sdiv_r = a[WIDTH-1] ? -mag_r : mag_r;
  assign udiv_q = a / b_nz;
  assign udiv_r = a % b_nz;

  // Decode the op into the result that would be committed and its class.
  always_comb begin
    res_hi   = hi;
    res_lo   = lo;
    res_dz   = 1'b0;
    is_multi = 1'b0;
    is_div   = 1'b0;
    case (op)
      OP_MULT: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        is_multi = 1'b1;
        is_div   = 1'b1;
        if (b == '0) begin
          res_dz = 1'b1;
        end else begin
          res_lo = sdiv_q;
          res_hi = sdiv_r;
        end
      end
      OP_DIVU: begin
        is_multi = 1'b1;
        is_div   = 1'b1;
        if (b == '0) begin
          res_dz = 1'b1;
        end else begin
          res_lo = udiv_q;
          res_hi = udiv_r;
        end
      end
`ifdef XALU_MADD_EN
      OP_MADD: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
      OP_MADDU: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_u;
      end
      OP_MSUB: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = {hi, lo} - prod_s;
      end
      OP_MSUBU: begin
        is_multi         = 1'b1;
        {res_hi, res_lo} = {hi, lo} - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM, latency counter, pending results and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else begin
      dz <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else if (is_multi) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_dz <= res_dz;
              counter <= is_div ? DIV_LOAD : MUL_LOAD;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else if (counter == '0) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            dz    <= pend_dz;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_param.sv
// tb_xalu_param: table-driven directed bench for xalu_param (WIDTH=32,
// MUL_LAT=5, DIV_LAT=10) plus hand sequences for cancel, start-while-busy
// and mid-operation reset. Accumulate expectations follow XALU_MADD_EN.
module tb_xalu_param;

  localparam logic [3:0] MULT = 4'd0, MULTU = 4'd1, DIV = 4'd2, DIVU = 4'd3;
  localparam logic [3:0] MTHI = 4'd4, MTLO = 4'd5, MADD = 4'd6, MADDU = 4'd7;
  localparam logic [3:0] MSUB = 4'd8, MSUBU = 4'd9, NOP = 4'd15;
`ifdef XALU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;
  logic        dz;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    logic        exp_dz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  xalu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .dz(dz)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op for one edge; returns at the negedge after that edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges with busy high, bounded.
  task automatic waitIdle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    applyStimulus(MTHI, h, 32'd0);
    applyStimulus(MTLO, l, 32'd0);
  endtask

  task automatic addVec(input int i, input string n, input logic [3:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lt);
    vecs[i].name = n; vecs[i].op = o; vecs[i].a = av; vecs[i].b = bv;
    vecs[i].pre_hi = ph; vecs[i].pre_lo = pl; vecs[i].exp_hi = eh; vecs[i].exp_lo = el;
    vecs[i].exp_dz = ed; vecs[i].lat = lt;
  endtask

  initial begin
    int cnt;
    addVec(0,  "mthi",       MTHI,  32'h12345678, 0, 0, 0, 32'h12345678, 0, 0, 0);
    addVec(1,  "mtlo",       MTLO,  32'h9ABCDEF0, 0, 32'h12345678, 0, 32'h12345678, 32'h9ABCDEF0, 0, 0);
    addVec(2,  "mult_neg",   MULT,  32'hFFFFFFFE, 3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 5);
    addVec(3,  "multu",      MULTU, 32'hFFFFFFFE, 3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 0, 5);
    addVec(4,  "mult_min",   MULT,  32'h80000000, 32'h80000000, 1, 1, 32'h40000000, 0, 0, 5);
    addVec(5,  "div_neg",    DIV,   32'hFFFFFFF9, 2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 10);
    addVec(6,  "div_min",    DIV,   32'h80000000, 32'hFFFFFFFF, 5, 5, 0, 32'h80000000, 0, 10);
    addVec(7,  "div_negb",   DIV,   7, 32'hFFFFFFFE, 0, 0, 1, 32'hFFFFFFFD, 0, 10);
    addVec(8,  "divu",       DIVU,  100, 7, 0, 0, 2, 14, 0, 10);
    addVec(9,  "divu_zero",  DIVU,  7, 0, 32'hAAAA5555, 32'h1234, 32'hAAAA5555, 32'h1234, 1, 10);
    addVec(10, "maddu",      MADDU, 1, 1, 0, 32'hFFFFFFFF,
           MADD_EN ? 32'd1 : 32'd0, MADD_EN ? 32'd0 : 32'hFFFFFFFF, 0, MADD_EN ? 5 : 0);
    addVec(11, "msubu",      MSUBU, 1, 1, 1, 0,
           MADD_EN ? 32'd0 : 32'd1, MADD_EN ? 32'hFFFFFFFF : 32'd0, 0, MADD_EN ? 5 : 0);
    addVec(12, "madd",       MADD,  32'hFFFFFFFF, 2, 0, 5, 0, MADD_EN ? 32'd3 : 32'd5, 0, MADD_EN ? 5 : 0);
    addVec(13, "msub",       MSUB,  32'hFFFFFFFF, 2, 0, 0, 0, MADD_EN ? 32'd2 : 32'd0, 0, MADD_EN ? 5 : 0);
    addVec(14, "nop",        NOP,   32'hDEAD, 32'hBEEF, 3, 4, 3, 4, 0, 0);

    // Reset held low two cycles, then released.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_dz", dz, 0);

    for (int i = 0; i < 15; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitIdle(cnt);
      checkOutput({vecs[i].name, "_lat"}, cnt, vecs[i].lat);
      checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      checkOutput({vecs[i].name, "_dz"}, dz, vecs[i].exp_dz);
      @(negedge clk);
      checkOutput({vecs[i].name, "_dz_off"}, dz, 0);
    end

    // Cancel a divide at its fourth busy cycle, for a normal and a zero divisor.
    for (int k = 0; k < 2; k++) begin
      logic sawdz;
      preload(32'h11, 32'h22);
      applyStimulus(DIV, 100, (k == 0) ? 32'd7 : 32'd0);
      repeat (3) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      checkOutput("cancel_busy", busy, 0);
      sawdz = 1'b0;
      repeat (12) begin
        @(negedge clk);
        sawdz = sawdz | dz | busy;
      end
      checkOutput("cancel_no_dz_busy", sawdz, 0);
      checkOutput("cancel_hi", hi, 32'h11);
      checkOutput("cancel_lo", lo, 32'h22);
    end

    // start and cancel together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MTHI; a = 32'hDEAD;
    @(negedge clk);
    checkOutput("sc_mthi_hi", hi, 32'h11);
    op = MULT; a = 3; b = 3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    checkOutput("sc_mult_busy", busy, 0);
    checkOutput("sc_mult_lo", lo, 32'h22);

    // start held on every cycle while busy: only the first MULT commits.
    applyStimulus(MULT, 2, 3);
    start = 1'b1; op = MULT; a = 5; b = 7;
    cnt = 1;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("hold_lat", cnt, 5);
    checkOutput("hold_hi", hi, 0);
    checkOutput("hold_lo", lo, 6);
    @(negedge clk);
    checkOutput("hold_no_requeue", busy, 0);

    // Reset pulsed during a divide: outputs clear and nothing commits later.
    preload(32'h55, 32'h66);
    applyStimulus(DIV, 100, 7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_hi", hi, 0);
    checkOutput("rst_mid_lo", lo, 0);
    checkOutput("rst_mid_dz", dz, 0);
    repeat (12) @(negedge clk);
    checkOutput("rst_late_busy", busy, 0);
    checkOutput("rst_late_hi", hi, 0);
    checkOutput("rst_late_lo", lo, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
